// File: rtl/pmod_button_unit.sv
`default_nettype none
// ============================================================================
// Module   : pmod_button_unit
// Brief    : PMOD push-button sync/debounce, press-to-command FIFO for IAGC
// Revision : 1.0
// ============================================================================
module pmod_button_unit #(
  parameter int NB_BUTTONS     = 4,
  parameter int CMD_CODE_SIZE  = 2,
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_SIZE  = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_BUTTONS-1:0]    i_btn,
  output logic                     o_cmd_valid,
  output logic [CMD_CODE_SIZE-1:0] o_cmd_code,
  input  logic                     i_cmd_ready,
  output logic [NB_BUTTONS-1:0]    o_btn_level,
  output logic [DROP_CNT_SIZE-1:0] o_drop_count
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_TICKS);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_TICKS - 1);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [NB_BUTTONS-1:0]    r_sync1;
  logic [NB_BUTTONS-1:0]    r_sync2;
  logic [NB_BUTTONS-1:0]    w_stable;
  logic [NB_BUTTONS-1:0]    w_rise;
  logic [NB_BUTTONS-1:0]    r_pending;
  logic [NB_BUTTONS-1:0]    w_pick_hot;
  logic [NB_BUTTONS-1:0]    w_clear;
  logic [CMD_CODE_SIZE-1:0] w_pick_idx;
  logic [CMD_CODE_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_ptr_w:0]         r_count;
  logic [DROP_CNT_SIZE-1:0] r_drop;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_TICKS consecutive differing samples.
  for (genvar gi = 0; gi < NB_BUTTONS; gi++) begin : g_debounce
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[gi] != r_stable) begin
        if (r_cnt == c_cnt_max) begin
          r_stable <= r_sync2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_stable[gi] = r_stable;
    assign w_rise[gi]   = r_sync2[gi] & ~r_stable & (r_cnt == c_cnt_max);
  end

  always_comb begin
    w_pick_idx = '0;
    for (int i = NB_BUTTONS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pick_idx = CMD_CODE_SIZE'(i);
    end
  end

  // Two's-complement trick isolates the lowest set pending bit.
  assign w_pick_hot = r_pending & (~r_pending + 1'b1);
  assign w_full     = (r_count == c_depth);
  assign w_push     = (|r_pending) & ~w_full;
  assign w_clear    = w_push ? w_pick_hot : '0;
  assign w_pop      = (r_count != '0) & i_cmd_ready;
  assign w_drop     = |(w_rise & r_pending & ~w_clear);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_rise;
      if (w_drop && (r_drop != {DROP_CNT_SIZE{1'b1}})) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_pick_idx;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_cmd_valid  = (r_count != '0);
  assign o_cmd_code   = r_mem[r_rd_ptr];
  assign o_btn_level  = w_stable;
  assign o_drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pmod_button_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmod_button_unit
// Brief    : Randomized + directed bench for pmod_button_unit with queue model
// Revision : 1.0
// ============================================================================
module tb_pmod_button_unit;

  localparam int NB = 4;
  localparam int CS = 2;
  localparam int T  = 4;
  localparam int D  = 4;
  localparam int DW = 8;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic [NB-1:0] i_btn;
  logic          o_cmd_valid;
  logic [CS-1:0] o_cmd_code;
  logic          i_cmd_ready;
  logic [NB-1:0] o_btn_level;
  logic [DW-1:0] o_drop_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 i_clock = ~i_clock;

  pmod_button_unit #(
    .NB_BUTTONS(NB), .CMD_CODE_SIZE(CS), .DEBOUNCE_TICKS(T),
    .FIFO_DEPTH(D), .DROP_CNT_SIZE(DW)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn),
    .o_cmd_valid(o_cmd_valid), .o_cmd_code(o_cmd_code),
    .i_cmd_ready(i_cmd_ready), .o_btn_level(o_btn_level),
    .o_drop_count(o_drop_count)
  );

  // Reference: acceptance = last T synchronized samples all opposite the
  // accepted level; presses become pending bits, tokens live in a queue.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pend = '0;
  logic [NB-1:0] m_win [T];
  logic [CS-1:0] m_q [$];
  int            m_drop = 0;

  initial for (int k = 0; k < T; k++) m_win[k] = '0;

  always @(posedge i_clock) begin
    logic [NB-1:0] flip, rise, clr;
    logic [CS-1:0] idx;
    logic          push, dropped;
    if (i_reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_drop = 0;
      for (int k = 0; k < T; k++) m_win[k] = '0;
      m_q.delete();
    end else begin
      for (int k = T - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_s2;
      flip = '1;
      for (int k = 0; k < T; k++) flip = flip & (m_win[k] ^ m_stable);
      rise = flip & ~m_stable;
      m_s2 = m_s1;
      m_s1 = i_btn;
      clr = '0; idx = '0; push = 1'b0;
      if (m_pend != '0 && m_q.size() < D) begin
        for (int b = NB - 1; b >= 0; b--) if (m_pend[b]) idx = CS'(b);
        push = 1'b1;
        clr[idx] = 1'b1;
      end
      dropped = |(rise & m_pend & ~clr);
      if (m_q.size() > 0 && i_cmd_ready) void'(m_q.pop_front());
      if (push) m_q.push_back(idx);
      m_pend = (m_pend & ~clr) | rise;
      if (dropped && m_drop < 255) m_drop++;
      m_stable = m_stable ^ flip;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clock) begin
    if (chk_en) begin
      chk("model_valid", 32'(o_cmd_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("model_code", 32'(o_cmd_code), 32'(m_q[0]));
      chk("model_level", 32'(o_btn_level), 32'(m_stable));
      chk("model_drop", 32'(o_drop_count), 32'(m_drop));
    end
  end

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic press_release(input int b);
    i_btn = NB'(1) << b;
    repeat (8) tick();
    i_btn = '0;
    repeat (8) tick();
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    i_reset = 1'b1; i_btn = '0; i_cmd_ready = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_valid", 32'(o_cmd_valid), 0);
    chk("rst_code", 32'(o_cmd_code), 0);
    chk("rst_level", 32'(o_btn_level), 0);
    chk("rst_drop", 32'(o_drop_count), 0);
    i_reset = 1'b0;
    repeat (20) tick();
    chk("idle_valid", 32'(o_cmd_valid), 0);

    // Single press on button 2: level after edge 6, token after edge 7.
    i_btn = 4'b0100;
    repeat (5) tick();
    chk("b2_level_e5", 32'(o_btn_level), 0);
    tick();
    chk("b2_level_e6", 32'(o_btn_level), 4);
    chk("b2_valid_e6", 32'(o_cmd_valid), 0);
    tick();
    chk("b2_valid_e7", 32'(o_cmd_valid), 1);
    chk("b2_code_e7", 32'(o_cmd_code), 2);
    tick();
    chk("b2_valid_e8", 32'(o_cmd_valid), 0);
    i_btn = '0;
    repeat (10) tick();
    chk("b2_release_valid", 32'(o_cmd_valid), 0);
    chk("b2_release_level", 32'(o_btn_level), 0);

    // Bouncing button 1 never settles.
    for (int k = 0; k < 10; k++) begin
      i_btn[1] = ~i_btn[1];
      repeat (2) tick();
    end
    i_btn = '0;
    repeat (10) tick();
    chk("bounce_level", 32'(o_btn_level), 0);
    chk("bounce_valid", 32'(o_cmd_valid), 0);

    // Simultaneous presses queue lowest index first.
    i_cmd_ready = 1'b0;
    i_btn = 4'b1011;
    repeat (12) tick();
    chk("multi_level", 32'(o_btn_level), 4'hb);
    chk("multi_valid", 32'(o_cmd_valid), 1);
    chk("multi_code0", 32'(o_cmd_code), 0);
    i_btn = '0;
    i_cmd_ready = 1'b1;
    tick();
    chk("multi_code1", 32'(o_cmd_code), 1);
    tick();
    chk("multi_code3", 32'(o_cmd_code), 3);
    tick();
    chk("multi_empty", 32'(o_cmd_valid), 0);
    repeat (10) tick();

    // Fill FIFO, leave button 0 pending, then drop a repeat press.
    i_cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) press_release(seq[k]);
    chk("fill_drop0", 32'(o_drop_count), 0);
    chk("fill_code", 32'(o_cmd_code), 0);
    press_release(0);
    chk("fill_drop1", 32'(o_drop_count), 1);
    i_cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_code", 32'(o_cmd_code), 32'(seq[k]));
      tick();
    end
    chk("drain_empty", 32'(o_cmd_valid), 0);

    // Reset discards queued tokens and the drop count.
    i_cmd_ready = 1'b0;
    i_btn = 4'b0011;
    repeat (8) tick();
    i_btn = '0;
    repeat (8) tick();
    chk("prerst_valid", 32'(o_cmd_valid), 1);
    i_reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(o_cmd_valid), 0);
    chk("midrst_drop", 32'(o_drop_count), 0);
    i_reset = 1'b0;
    i_cmd_ready = 1'b1;
    repeat (10) tick();
    chk("postrst_valid", 32'(o_cmd_valid), 0);

    // Randomized traffic, occasionally starving the consumer or resetting.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) i_btn = NB'($urandom_range(0, 15));
      else i_btn = i_btn ^ (NB'(1) << $urandom_range(0, NB - 1));
      i_cmd_ready = ($urandom_range(0, 3) != 0) && (k % 80 > 30);
      i_reset = ($urandom_range(0, 199) == 0);
      repeat ($urandom_range(1, 8)) tick();
      i_reset = 1'b0;
    end
    i_btn = '0;
    i_cmd_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
